// File: rtl/mult_div_unit.sv
// Sequential MIPS mult/multu/div/divu unit: shift-add multiply and
// restoring divide over 32 iterations, sign fix-up applied at the end.
module mult_div_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FIX,
    S_DONE
  } state_e;

  state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic is_div_q, is_div_d;
  logic neg_p_q, neg_p_d;
  logic neg_r_q, neg_r_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic dbz_q, dbz_d;

  logic a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic accept;
  logic [WIDTH:0] add_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0] rem_sh, diff;
  logic q_bit;
  logic [WIDTH-1:0] new_rem;
  logic [2*WIDTH-1:0] div_next;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0] quo_fix, rem_fix;

  assign a_neg = op[0] & operand_a[WIDTH-1];
  assign b_neg = op[0] & operand_b[WIDTH-1];
  assign a_mag = a_neg ? -operand_a : operand_a;
  assign b_mag = b_neg ? -operand_b : operand_b;
  assign accept = start &
                  ((state_q == S_IDLE) | (state_q == S_DONE));

  // acc holds {partial product, multiplier} or {remainder, dividend/quotient}
  assign add_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} +
                   (acc_q[0] ? {1'b0, opb_q} : '0);
  assign mul_next = {add_sum, acc_q[WIDTH-1:1]};

  assign rem_sh = acc_q[2*WIDTH-1:WIDTH-1];
  assign diff = rem_sh - {1'b0, opb_q};
  assign q_bit = ~diff[WIDTH];
  assign new_rem = q_bit ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
  assign div_next = {new_rem, acc_q[WIDTH-2:0], q_bit};

  assign prod_fix = neg_p_q ? -acc_q : acc_q;
  assign quo_fix = neg_p_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
  assign rem_fix = neg_r_q ? -acc_q[2*WIDTH-1:WIDTH]
                           : acc_q[2*WIDTH-1:WIDTH];

  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    acc_d = acc_q;
    opb_d = opb_q;
    is_div_d = is_div_q;
    neg_p_d = neg_p_q;
    neg_r_d = neg_r_q;
    hi_d = hi_q;
    lo_d = lo_q;
    dbz_d = dbz_q;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (state_q == S_DONE) state_d = S_IDLE;
        if (accept) begin
          if (op[1] && (operand_b == '0)) begin
            state_d = S_DONE;
            hi_d = operand_a;
            lo_d = '1;
            dbz_d = 1'b1;
          end else begin
            state_d = S_RUN;
            cnt_d = '0;
            acc_d = op[1] ? {{WIDTH{1'b0}}, a_mag}
                          : {{WIDTH{1'b0}}, b_mag};
            opb_d = op[1] ? b_mag : a_mag;
            is_div_d = op[1];
            neg_p_d = a_neg ^ b_neg;
            neg_r_d = a_neg;
            dbz_d = 1'b0;
          end
        end
      end
      S_RUN: begin
        if (cnt_q == CNT_W'(WIDTH)) begin
          state_d = S_FIX;
        end else begin
          acc_d = is_div_q ? div_next : mul_next;
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_FIX: begin
        state_d = S_DONE;
        hi_d = is_div_q ? rem_fix : prod_fix[2*WIDTH-1:WIDTH];
        lo_d = is_div_q ? quo_fix : prod_fix[WIDTH-1:0];
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q <= '0;
      acc_q <= '0;
      opb_q <= '0;
      is_div_q <= 1'b0;
      neg_p_q <= 1'b0;
      neg_r_q <= 1'b0;
      hi_q <= '0;
      lo_q <= '0;
      dbz_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      acc_q <= acc_d;
      opb_q <= opb_d;
      is_div_q <= is_div_d;
      neg_p_q <= neg_p_d;
      neg_r_q <= neg_r_d;
      hi_q <= hi_d;
      lo_q <= lo_d;
      dbz_q <= dbz_d;
    end
  end

  assign busy = (state_q == S_RUN) | (state_q == S_FIX);
  assign done = (state_q == S_DONE);
  assign div_by_zero = dbz_q;
  assign hi = hi_q;
  assign lo = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: directed ops, latency,
// hold, ignored start, divide-by-zero and async reset abort.
module tb_mult_div_unit;

  localparam int W = 32;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic start = 1'b0;
  logic [1:0] op = 2'b00;
  logic [W-1:0] operand_a = '0;
  logic [W-1:0] operand_b = '0;
  logic busy, done, div_by_zero;
  logic [W-1:0] hi, lo;

  mult_div_unit #(.WIDTH(W), .CNT_W(6)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .start(start),
    .op(op),
    .operand_a(operand_a),
    .operand_b(operand_b),
    .busy(busy),
    .done(done),
    .div_by_zero(div_by_zero),
    .hi(hi),
    .lo(lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic dbz;
    int cyc;
    int nbusy;
  } exp_t;

  exp_t sb[$];
  int cyc = 0;
  int n_vec = 0;
  int n_bad = 0;
  int busy_cnt = 0;
  logic [W-1:0] held_hi = '0;
  logic [W-1:0] held_lo = '0;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (!reset_n) begin
      held_hi = '0;
      held_lo = '0;
      busy_cnt = 0;
    end else if (done) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL spurious_done: got done=1, expected none (cycle %0d)",
                 cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("hi", hi, e.hi);
        chk("lo", lo, e.lo);
        chk("div_by_zero", div_by_zero, e.dbz);
        chk("done_cycle", cyc, e.cyc);
        chk("busy_cycles", busy_cnt, e.nbusy);
        chk("busy_at_done", busy, 0);
        held_hi = e.hi;
        held_lo = e.lo;
        busy_cnt = 0;
      end
    end else begin
      if (busy) busy_cnt++;
      chk("hold_hi", hi, held_hi);
      chk("hold_lo", lo, held_lo);
    end
  end

  task automatic issue(input logic [1:0] o, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [W-1:0] eh,
                       input logic [W-1:0] el, input logic ed);
    int t;
    t = 0;
    while (busy && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("issue_wait_busy", busy, 0);
    op = o;
    operand_a = a;
    operand_b = b;
    start = 1'b1;
    sb.push_back('{hi: eh, lo: el, dbz: ed,
                   cyc: cyc + (ed ? 1 : 35), nbusy: (ed ? 0 : 34)});
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done();
    int t;
    t = 0;
    while (!done && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("wait_done", done, 1);
  endtask

  initial begin
    int t;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_dbz", div_by_zero, 0);
    chk("rst_hi", hi, 0);
    chk("rst_lo", lo, 0);
    reset_n = 1'b1;
    @(negedge clk);

    issue(2'b00, 32'd1025, 32'd11, 32'd0, 32'd11275, 1'b0);
    issue(2'b01, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0);
    issue(2'b11, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
    issue(2'b10, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0);
    wait_done();
    repeat (3) @(negedge clk);

    issue(2'b10, 32'd100, 32'd0, 32'd100, 32'hFFFFFFFF, 1'b1);
    issue(2'b00, 32'd2, 32'd3, 32'd0, 32'd6, 1'b0);

    issue(2'b00, 32'd1025, 32'd11, 32'd0, 32'd11275, 1'b0);
    repeat (9) @(negedge clk);
    op = 2'b01;
    operand_a = 32'd7;
    operand_b = 32'd9;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    op = 2'b10;
    operand_a = 32'hDEADBEEF;
    operand_b = 32'h12345678;

    issue(2'b11, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000, 1'b0);
    issue(2'b01, 32'h80000000, 32'h80000000, 32'h40000000, 32'd0, 1'b0);
    issue(2'b10, 32'hFFFFFFFF, 32'd1, 32'd0, 32'hFFFFFFFF, 1'b0);
    issue(2'b11, 32'd7, 32'hFFFFFFFE, 32'd1, 32'hFFFFFFFD, 1'b0);
    wait_done();
    @(negedge clk);

    issue(2'b00, 32'h12345678, 32'h10, 32'h1, 32'h23456780, 1'b0);
    repeat (19) @(negedge clk);
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    sb.delete();
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_hi", hi, 0);
    chk("abort_lo", lo, 0);
    chk("abort_dbz", div_by_zero, 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    issue(2'b00, 32'd5, 32'd5, 32'd0, 32'd25, 1'b0);

    t = 0;
    while (sb.size() != 0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("drain", sb.size(), 0);
    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
